// File: rtl/minibyte_bus_arbiter.sv
// Arbitrates the minibyte 8-bit memory/IO bus between the CPU and a loader master.
// The loader gets the bus only after the CPU has been halted for a settle window.
module minibyte_bus_arbiter #(
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_BURST     = 16,
  parameter int CPU_MIN       = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ena_in,
  input  logic       halt_in,
  input  logic [7:0] cpu_addr_in,
  input  logic [7:0] cpu_wdata_in,
  input  logic       cpu_we_in,
  input  logic       cpu_drive_in,
  output logic [7:0] cpu_rdata_out,
  output logic       cpu_halt_out,
  input  logic       ld_req_in,
  input  logic       ld_valid_in,
  input  logic       ld_we_in,
  input  logic [7:0] ld_addr_in,
  input  logic [7:0] ld_wdata_in,
  output logic       ld_grant_out,
  output logic       ld_ready_out,
  output logic [7:0] ld_rdata_out,
  output logic       ld_rvalid_out,
  output logic [7:0] mem_addr_out,
  output logic [7:0] mem_data_out,
  output logic       mem_we_out,
  output logic       mem_drive_out,
  input  logic [7:0] mem_data_in
);

  typedef enum logic [2:0] {
    CPU_OWN,
    HALT_WAIT,
    LD_OWN,
    LD_XFER,
    RELEASE
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] BURST_MAX   = 8'(MAX_BURST);
  localparam logic [7:0] HOLD_LOAD   = 8'(CPU_MIN);

  state_t     state, state_nxt;
  logic [3:0] settle_q, settle_nxt;
  logic [7:0] burst_q, burst_nxt;
  logic [7:0] holdoff_q, holdoff_nxt;
  logic [7:0] ld_addr_q, ld_wdata_q, ld_rdata_q;
  logic       ld_we_q, ld_rvalid_q;
  logic       arb_halt, burst_full, accept;

  assign burst_full = (burst_q == BURST_MAX);
  assign accept     = ld_ready_out && ld_valid_in;

  always_comb begin
    state_nxt    = state;
    settle_nxt   = settle_q;
    burst_nxt    = burst_q;
    holdoff_nxt  = holdoff_q;
    arb_halt     = 1'b0;
    ld_grant_out = 1'b0;
    ld_ready_out = 1'b0;
    case (state)
      CPU_OWN: begin
        if (holdoff_q != 8'd0) holdoff_nxt = holdoff_q - 8'd1;
        if (ld_req_in && ena_in && holdoff_q == 8'd0) begin
          state_nxt  = HALT_WAIT;
          settle_nxt = SETTLE_LOAD;
        end
      end
      HALT_WAIT: begin
        arb_halt = 1'b1;
        if (!ld_req_in)              state_nxt  = CPU_OWN;
        else if (settle_q == 4'd0)   state_nxt  = LD_OWN;
        else                         settle_nxt = settle_q - 4'd1;
      end
      LD_OWN: begin
        arb_halt     = 1'b1;
        ld_grant_out = 1'b1;
        // a full burst wins over a same-cycle strobe: ready stays low
        ld_ready_out = !burst_full;
        if (burst_full) begin
          state_nxt = RELEASE;
        end else if (ld_valid_in) begin
          state_nxt = LD_XFER;
          burst_nxt = burst_q + 8'd1;
        end else if (!ld_req_in) begin
          state_nxt = RELEASE;
        end
      end
      LD_XFER: begin
        arb_halt     = 1'b1;
        ld_grant_out = 1'b1;
        state_nxt    = LD_OWN;
      end
      RELEASE: begin
        burst_nxt   = 8'd0;
        holdoff_nxt = HOLD_LOAD;
        state_nxt   = CPU_OWN;
      end
      default: state_nxt = CPU_OWN;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= CPU_OWN;
      settle_q  <= 4'd0;
      burst_q   <= 8'd0;
      holdoff_q <= 8'd0;
    end else begin
      state     <= state_nxt;
      settle_q  <= settle_nxt;
      burst_q   <= burst_nxt;
      holdoff_q <= holdoff_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ld_addr_q   <= 8'h00;
      ld_wdata_q  <= 8'h00;
      ld_we_q     <= 1'b0;
      ld_rdata_q  <= 8'h00;
      ld_rvalid_q <= 1'b0;
    end else begin
      if (accept) begin
        ld_addr_q  <= ld_addr_in;
        ld_wdata_q <= ld_wdata_in;
        ld_we_q    <= ld_we_in;
      end
      // read data is taken at the end of the transfer cycle, flagged one cycle later
      ld_rvalid_q <= (state == LD_XFER) && !ld_we_q;
      if (state == LD_XFER && !ld_we_q) ld_rdata_q <= mem_data_in;
    end
  end

  // Bus mux: CPU passes straight through until the loader is granted
  always_comb begin
    mem_addr_out  = ld_addr_q;
    mem_data_out  = ld_wdata_q;
    mem_we_out    = 1'b0;
    mem_drive_out = 1'b0;
    case (state)
      CPU_OWN, HALT_WAIT: begin
        mem_addr_out  = cpu_addr_in;
        mem_data_out  = cpu_wdata_in;
        mem_we_out    = cpu_we_in;
        mem_drive_out = cpu_drive_in;
      end
      LD_XFER: begin
        mem_we_out    = ld_we_q;
        mem_drive_out = ld_we_q;
      end
      default: ;
    endcase
  end

  assign cpu_halt_out  = arb_halt | halt_in;
  assign cpu_rdata_out = mem_data_in;
  assign ld_rdata_out  = ld_rdata_q;
  assign ld_rvalid_out = ld_rvalid_q;

endmodule

// File: tb/tb_minibyte_bus_arbiter.sv
// Bench for minibyte_bus_arbiter: vector table, directed corner sequences and a
// randomized run compared cycle by cycle against a flag/age based reference model.
module tb_minibyte_bus_arbiter;
  localparam int SETTLE = 4, MAXB = 16, CMIN = 8;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       ena_in = 1'b1, halt_in = 1'b0;
  logic [7:0] cpu_addr_in = 8'h00, cpu_wdata_in = 8'h00;
  logic       cpu_we_in = 1'b0, cpu_drive_in = 1'b0;
  logic       ld_req_in = 1'b0, ld_valid_in = 1'b0, ld_we_in = 1'b0;
  logic [7:0] ld_addr_in = 8'h00, ld_wdata_in = 8'h00, mem_data_in = 8'h00;
  logic [7:0] cpu_rdata_out, ld_rdata_out, mem_addr_out, mem_data_out;
  logic       cpu_halt_out, ld_grant_out, ld_ready_out, ld_rvalid_out;
  logic       mem_we_out, mem_drive_out;

  minibyte_bus_arbiter #(.SETTLE_CYCLES(SETTLE), .MAX_BURST(MAXB), .CPU_MIN(CMIN)) dut (
    .clk_in(clk), .rst_in(rst_n), .ena_in(ena_in), .halt_in(halt_in),
    .cpu_addr_in(cpu_addr_in), .cpu_wdata_in(cpu_wdata_in), .cpu_we_in(cpu_we_in),
    .cpu_drive_in(cpu_drive_in), .cpu_rdata_out(cpu_rdata_out), .cpu_halt_out(cpu_halt_out),
    .ld_req_in(ld_req_in), .ld_valid_in(ld_valid_in), .ld_we_in(ld_we_in),
    .ld_addr_in(ld_addr_in), .ld_wdata_in(ld_wdata_in), .ld_grant_out(ld_grant_out),
    .ld_ready_out(ld_ready_out), .ld_rdata_out(ld_rdata_out), .ld_rvalid_out(ld_rvalid_out),
    .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .mem_we_out(mem_we_out),
    .mem_drive_out(mem_drive_out), .mem_data_in(mem_data_in)
  );

  int total = 0, bad = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: loader ownership as flags, settle time and holdoff as ages counting up
  int         m_settle, m_acc, m_since;
  bit         m_grant, m_xfer, m_rel, m_we, m_rvalid;
  logic [7:0] m_addr, m_data, m_rdata;

  function automatic void model_reset();
    m_settle = 0; m_acc = 0; m_since = CMIN;
    m_grant = 0; m_xfer = 0; m_rel = 0; m_we = 0; m_rvalid = 0;
    m_addr = 8'h00; m_data = 8'h00; m_rdata = 8'h00;
  endfunction

  task automatic model_check();
    bit cpu_side;
    logic [7:0] ea, ed;
    logic ew, edr;
    cpu_side = !m_grant && !m_rel;
    ea  = cpu_side ? cpu_addr_in  : m_addr;
    ed  = cpu_side ? cpu_wdata_in : m_data;
    ew  = cpu_side ? cpu_we_in    : (m_xfer && m_we);
    edr = cpu_side ? cpu_drive_in : (m_xfer && m_we);
    chk("model_bus", {mem_addr_out, mem_data_out, mem_we_out, mem_drive_out}, {ea, ed, ew, edr});
    chk("model_ctl", {cpu_halt_out, ld_grant_out, ld_ready_out, ld_rvalid_out},
        {(m_settle > 0 || m_grant || halt_in), m_grant,
         (m_grant && !m_xfer && m_acc < MAXB), m_rvalid});
    chk("model_rd", {ld_rdata_out, cpu_rdata_out}, {m_rdata, mem_data_in});
  endtask

  function automatic void model_step();
    bit rd_done;
    rd_done = m_xfer && !m_we;
    if (rd_done) m_rdata = mem_data_in;
    m_rvalid = rd_done;
    if (m_rel) begin
      m_rel = 0; m_acc = 0; m_since = 0;
    end else if (m_grant) begin
      if (m_xfer) m_xfer = 0;
      else if (m_acc == MAXB) begin m_grant = 0; m_rel = 1; end
      else if (ld_valid_in) begin
        m_addr = ld_addr_in; m_data = ld_wdata_in; m_we = ld_we_in; m_acc++; m_xfer = 1;
      end else if (!ld_req_in) begin m_grant = 0; m_rel = 1; end
    end else if (m_settle > 0) begin
      if (!ld_req_in) m_settle = 0;
      else if (m_settle == SETTLE) begin m_settle = 0; m_grant = 1; end
      else m_settle++;
    end else begin
      if (ld_req_in && ena_in && m_since >= CMIN) m_settle = 1;
      if (m_since < CMIN) m_since++;
    end
  endfunction

  // One clock: model compare mid-cycle, model advance on the edge, return 1 after it
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_step();
    cyc++;
    #1;
  endtask

  task automatic wait_grant(input string nm);
    int i;
    i = 0;
    #1;
    while (!ld_grant_out && i < 30) begin step(); #1; i++; end
    chk(nm, ld_grant_out, 1'b1);
  endtask

  typedef struct {
    logic [7:0] addr, wdata, mdin;
    logic       we, drive, halt;
    logic [7:0] e_addr, e_data, e_rd;
    logic       e_we, e_drive, e_halt;
  } vec_t;
  vec_t tbl[6];

  int acc, gap, seen, done;
  bit any_grant, any_halt, we_bad, saw_rv;

  initial begin
    tbl[0] = '{8'h3C, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h00, 8'h11, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h55, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h00, 8'h55, 8'hFF, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{8'h81, 8'h7E, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h81, 8'h7E, 8'hA5, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h10, 8'hC3, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h10, 8'hC3, 8'h5A, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'h42, 8'h24, 8'h99, 1'b0, 1'b1, 1'b0, 8'h42, 8'h24, 8'h99, 1'b0, 1'b1, 1'b0};

    // reset state with the CPU driving the bus
    model_reset();
    cpu_addr_in = 8'h3C; cpu_we_in = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mem_addr", mem_addr_out, 8'h3C);
    chk("rst_mem_we", mem_we_out, 1'b1);
    chk("rst_halt", cpu_halt_out, 1'b0);
    chk("rst_grant_ready_rv", {ld_grant_out, ld_ready_out, ld_rvalid_out}, 3'b000);
    chk("rst_rdata", ld_rdata_out, 8'h00);
    step(); step();
    rst_n = 1'b1;
    step();

    // CPU passthrough vectors
    for (int i = 0; i < 6; i++) begin
      cpu_addr_in = tbl[i].addr; cpu_wdata_in = tbl[i].wdata; cpu_we_in = tbl[i].we;
      cpu_drive_in = tbl[i].drive; halt_in = tbl[i].halt; mem_data_in = tbl[i].mdin;
      #1;
      chk("vec_bus", {mem_addr_out, mem_data_out, mem_we_out, mem_drive_out},
          {tbl[i].e_addr, tbl[i].e_data, tbl[i].e_we, tbl[i].e_drive});
      chk("vec_halt_rd", {cpu_halt_out, ld_grant_out, cpu_rdata_out},
          {tbl[i].e_halt, 1'b0, tbl[i].e_rd});
      step();
    end
    halt_in = 1'b0;

    // settle window: halt from cycle 1, grant at cycle SETTLE+1
    cpu_addr_in = 8'h77; cpu_we_in = 1'b1; ld_req_in = 1'b1;
    for (int k = 0; k <= SETTLE + 1; k++) begin
      #1;
      chk("settle_halt", cpu_halt_out, (k >= 1) ? 1'b1 : 1'b0);
      chk("settle_grant", ld_grant_out, (k == SETTLE + 1) ? 1'b1 : 1'b0);
      if (k <= SETTLE) chk("settle_passthru", {mem_addr_out, mem_we_out}, {8'h77, 1'b1});
      step();
    end

    // loader write then read-back
    ld_valid_in = 1'b1; ld_we_in = 1'b1; ld_addr_in = 8'h10; ld_wdata_in = 8'hA5;
    #1 chk("wr_ready", ld_ready_out, 1'b1);
    step();
    ld_valid_in = 1'b0;
    #1 chk("wr_bus", {mem_addr_out, mem_data_out, mem_we_out, mem_drive_out},
           {8'h10, 8'hA5, 1'b1, 1'b1});
    step();
    ld_valid_in = 1'b1; ld_we_in = 1'b0;
    step();
    ld_valid_in = 1'b0; mem_data_in = 8'hA5;
    #1 chk("rd_xfer_we", {mem_we_out, mem_drive_out, ld_rvalid_out}, 3'b000);
    step();
    mem_data_in = 8'h00;
    #1 chk("rd_rvalid", {ld_rvalid_out, ld_rdata_out}, {1'b1, 8'hA5});
    step();
    #1 chk("rd_rvalid_pulse", ld_rvalid_out, 1'b0);
    ld_req_in = 1'b0;
    step();
    #1 chk("release_idle", {cpu_halt_out, ld_grant_out, mem_we_out, mem_drive_out}, 4'b0000);
    repeat (CMIN + 2) step();

    // back-to-back burst, then holdoff before the next halt
    ld_req_in = 1'b1; ld_valid_in = 1'b1; ld_we_in = 1'b1;
    acc = 0; seen = 0; done = 0;
    for (int i = 0; i < 80 && done == 0; i++) begin
      ld_addr_in = 8'(i);
      #1;
      if (ld_valid_in && ld_ready_out) acc++;
      if (ld_grant_out) seen = 1;
      else if (seen != 0) done = 1;
      if (done == 0) step();
    end
    chk("burst_released", done, 1);
    chk("burst_accepts", acc, MAXB);
    chk("burst_halt_drop", cpu_halt_out, 1'b0);
    gap = 0;
    for (int j = 0; j < 40 && gap == 0; j++) begin
      step();
      #1 if (cpu_halt_out) gap = j + 1;
    end
    chk("holdoff_gap", gap, CMIN + 2);
    ld_req_in = 1'b0; ld_valid_in = 1'b0;
    repeat (4) step();

    // request pulse shorter than the settle window
    any_grant = 0; we_bad = 0;
    for (int i = 0; i < 10; i++) begin
      ld_req_in = (i < 2); cpu_we_in = i[0];
      #1;
      any_grant |= ld_grant_out;
      we_bad |= (mem_we_out !== cpu_we_in);
      step();
    end
    chk("pulse_no_grant", any_grant, 1'b0);
    chk("pulse_cpu_we", we_bad, 1'b0);

    // arbitration disabled, then external halt
    ena_in = 1'b0; ld_req_in = 1'b1; any_grant = 0; any_halt = 0;
    for (int i = 0; i < 12; i++) begin
      #1; any_grant |= ld_grant_out; any_halt |= cpu_halt_out;
      step();
    end
    chk("ena0_no_grant", {any_grant, any_halt}, 2'b00);
    halt_in = 1'b1;
    #1 chk("ext_halt", {cpu_halt_out, ld_grant_out}, 2'b10);
    ena_in = 1'b1;
    wait_grant("grant_with_halt_in");
    halt_in = 1'b0;

    // reset during a write transfer returns the bus to the CPU at once
    ld_valid_in = 1'b1; ld_we_in = 1'b1; ld_addr_in = 8'h5A; ld_wdata_in = 8'hC3;
    step();
    ld_valid_in = 1'b0; cpu_we_in = 1'b0; cpu_addr_in = 8'h11;
    #1 chk("xfer_loader_bus", {mem_addr_out, mem_we_out}, {8'h5A, 1'b1});
    rst_n = 1'b0;
    #1 chk("rst_xfer_bus", {mem_addr_out, mem_we_out, ld_grant_out, cpu_halt_out},
           {8'h11, 1'b0, 1'b0, 1'b0});
    model_reset();
    step();
    rst_n = 1'b1;
    step();

    // reset during a read transfer drops the pending rvalid
    wait_grant("grant_before_rd_rst");
    ld_valid_in = 1'b1; ld_we_in = 1'b0;
    step();
    ld_valid_in = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    saw_rv = 0;
    for (int i = 0; i < 3; i++) begin
      #1 saw_rv |= ld_rvalid_out;
      step();
      if (i == 1) rst_n = 1'b1;
    end
    chk("rst_drops_rvalid", saw_rv, 1'b0);
    ld_req_in = 1'b0;
    repeat (3) step();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ena_in       = ($urandom_range(0, 7) != 0);
      halt_in      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) ld_req_in = ~ld_req_in;
      ld_valid_in  = $urandom_range(0, 1);
      ld_we_in     = $urandom_range(0, 1);
      ld_addr_in   = 8'($urandom);
      ld_wdata_in  = 8'($urandom);
      cpu_addr_in  = 8'($urandom);
      cpu_wdata_in = 8'($urandom);
      cpu_we_in    = $urandom_range(0, 1);
      cpu_drive_in = $urandom_range(0, 1);
      mem_data_in  = 8'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/minibyte_bus_arbiter.md
Name: minibyte_bus_arbiter

Overview:
- Shares the single 8-bit external memory/IO bus between the minibyte CPU core and a loader/debug master (e.g. a serial program loader).
- Sits between the CPU's addr/data/we/drive pins and the physical bus.
- Halts the CPU, waits a settle window, grants the bus to the loader for a bounded burst, then returns ownership with a CPU hold-off to prevent starvation.

Parameters:
- SETTLE_CYCLES, 4: cycles halt is held before loader grant (1..15).
- MAX_BURST, 16: loader transactions per grant before forced release (1..255).
- CPU_MIN, 8: CPU_OWN cycles during which a new loader request is ignored after release (0..255).

Ports:
- clk_in  in  1  clock, all state on rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- ena_in  in  1  arbitration enable; when 0, no new grant starts.
- halt_in  in  1  external halt request, ORed into cpu_halt_out.
- cpu_addr_in  in  8  CPU address.
- cpu_wdata_in  in  8  CPU write data.
- cpu_we_in  in  1  CPU write enable.
- cpu_drive_in  in  1  CPU data drive enable.
- cpu_rdata_out  out  8  read data to CPU; equals mem_data_in at all times.
- cpu_halt_out  out  1  halt to CPU.
- ld_req_in  in  1  loader bus request (level).
- ld_valid_in  in  1  loader transaction strobe.
- ld_we_in  in  1  1 = write, 0 = read.
- ld_addr_in  in  8  loader address.
- ld_wdata_in  in  8  loader write data.
- ld_grant_out  out  1  loader owns bus.
- ld_ready_out  out  1  transaction accepted when ld_valid_in && ld_ready_out.
- ld_rdata_out  out  8  read data.
- ld_rvalid_out  out  1  one-cycle pulse, ld_rdata_out valid.
- mem_addr_out  out  8  bus address.
- mem_data_out  out  8  bus write data.
- mem_we_out  out  1  bus write enable.
- mem_drive_out  out  1  bus drive enable.
- mem_data_in  in  8  bus read data.

Behaviour:
- States: CPU_OWN, HALT_WAIT, LD_OWN, LD_XFER, RELEASE. Reset enters CPU_OWN with all counters cleared.
- Reset values: arb_halt, ld_grant_out, ld_ready_out, ld_rvalid_out = 0; ld_rdata_out = 0x00. Reset mid-transfer aborts immediately: the bus returns to the CPU mux and any pending rvalid is dropped.
- cpu_halt_out = arb_halt | halt_in. arb_halt is 1 in HALT_WAIT, LD_OWN and LD_XFER only.
- Bus mux: in CPU_OWN and HALT_WAIT, mem_* = cpu_* combinationally, so the CPU completes an in-flight cycle.
- In LD_OWN and RELEASE: mem_we_out = 0, mem_drive_out = 0, mem_addr_out/mem_data_out hold the last loader values (0x00 after reset).
- In LD_XFER: mem_* come from the registered loader transaction.
- CPU_OWN -> HALT_WAIT: when ld_req_in && ena_in && holdoff == 0. The settle counter loads SETTLE_CYCLES-1.
- HALT_WAIT:
  - Counter decrements each cycle.
  - At 0 -> LD_OWN, so the grant rises exactly SETTLE_CYCLES+1 cycles after the request is sampled.
  - If ld_req_in drops -> CPU_OWN with no grant.
- LD_OWN:
  - ld_grant_out = 1, ld_ready_out = 1.
  - On accept: register addr/wdata/we, increment the burst counter, go to LD_XFER.
  - If ld_req_in = 0 with no valid, or burst == MAX_BURST -> RELEASE.
- LD_XFER (exactly 1 cycle):
  - ld_ready_out = 0; drive mem_addr_out/mem_data_out; mem_we_out = ld_we, mem_drive_out = ld_we.
  - On a read, capture mem_data_in into ld_rdata_out at the end of the cycle; ld_rvalid_out pulses on the next cycle.
  - Returns to LD_OWN. Throughput is 1 transaction per 2 cycles.
- RELEASE (1 cycle):
  - Grant and arb_halt are 0; the bus is idle.
  - Burst counter clears; the holdoff counter loads CPU_MIN; next state is CPU_OWN.
- Holdoff decrements in CPU_OWN down to 0 and saturates there.
- ena_in = 0 only blocks the CPU_OWN -> HALT_WAIT transition; an active grant completes normally.
- halt_in is independent of arbitration: a loader grant still proceeds while halt_in = 1.
- Simultaneous ld_valid_in on the same cycle that burst hits MAX_BURST: not accepted (ready = 0 in that cycle); RELEASE is taken.

Test Plan:
- Reset with cpu_addr_in = 0x3C, cpu_we_in = 1 -> mem_addr_out = 0x3C, mem_we_out = 1, cpu_halt_out = 0, ld_grant_out = 0; asserting rst_in = 0 mid-LD_XFER -> mem_we_out follows the CPU in the same cycle.
- ld_req_in rises at cycle 0 with SETTLE_CYCLES = 4 -> cpu_halt_out = 1 from cycle 1; ld_grant_out = 1 at cycle 5; CPU signals pass through until cycle 5.
- Loader write addr 0x10, data 0xA5 -> one cycle with mem_addr_out = 0x10, mem_data_out = 0xA5, mem_we_out = 1, mem_drive_out = 1. Then a read of 0x10 with mem_data_in = 0xA5 -> ld_rvalid_out pulses with ld_rdata_out = 0xA5, two cycles after accept.
- ld_req_in held with back-to-back valid, MAX_BURST = 16 -> exactly 16 accepts, RELEASE, halt drops. A new grant is not requested until CPU_MIN = 8 CPU_OWN cycles have elapsed.
- ld_req_in pulses for 2 cycles during HALT_WAIT -> return to CPU_OWN, ld_grant_out never 1, mem_we_out never driven by the loader.
- ena_in = 0 with ld_req_in = 1 -> stays in CPU_OWN. Separately, halt_in = 1 in CPU_OWN -> cpu_halt_out = 1 with ld_grant_out = 0.
